// File: rtl/minitb_ahb_arbiter_pkg.sv
// Shared types and constants for the miniTB AHB arbiter.
// Holds htrans encodings, arbiter state enum and one-hot decode.
package minitb_ahb_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    typedef enum logic {
        GRANTED = 1'b0,
        LOCKED  = 1'b1
    } arb_state_e;

    function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/minitb_ahb_arbiter_if.sv
// Arbitration sideband between AHB masters, bus mux and arbiter.
// The slave modport is the arbiter's view.
interface minitb_ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4
) ();
    localparam int MW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MW-1:0]          hmaster;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hready,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/minitb_rr_arbiter.sv
// Combinational rotating-priority select starting after i_ptr.
// The pointer's own requester is considered last.
module minitb_rr_arbiter #(
    parameter  int NUM_MASTERS = 4,
    localparam int MW = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [MW-1:0]          i_ptr,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic                   o_valid
);
    logic [NUM_MASTERS-1:0] w_grant;
    logic                   w_found;
    int                     w_j;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_MASTERS;
            if (!w_found && i_req[w_j]) begin
                w_grant[w_j] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign o_grant = w_grant;
    assign o_valid = w_found;
endmodule

// File: rtl/minitb_ahb_arbiter.sv
// Round-robin AHB arbiter with locked transfers and a default master.
// Grant moves at arbitration points; hmaster follows on hready.
module minitb_ahb_arbiter
    import minitb_ahb_pkg::*;
#(
    parameter  int NUM_MASTERS    = 4,
    parameter  int DEFAULT_MASTER = 0,
    localparam int MW = $clog2(NUM_MASTERS)
) (
    input logic                hclk,
    input logic                hresetn,
    minitb_ahb_arbiter_if.slave bus
);
    localparam logic [NUM_MASTERS-1:0] DEF_OH =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [MW-1:0]          r_rr_ptr;
    logic [MW-1:0]          r_hmaster;
    logic                   r_hmastlock;

    logic [NUM_MASTERS-1:0] w_req_lock;
    logic [NUM_MASTERS-1:0] w_sel_oh;
    logic                   w_sel_valid;
    logic [NUM_MASTERS-1:0] w_new_oh;
    logic [MW-1:0]          w_new_idx;
    logic                   w_new_lock;
    logic [MW-1:0]          w_own_idx;
    logic                   w_own_lock;
    logic                   w_arb_pt;
    logic                   w_rearb;

    minitb_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
        .i_req   (bus.hbusreq),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_sel_oh),
        .o_valid (w_sel_valid)
    );

    // A lock only counts while the same master is also requesting.
    assign w_req_lock = bus.hlock & bus.hbusreq;

    assign w_new_oh   = w_sel_valid ? w_sel_oh : DEF_OH;
    assign w_new_idx  = MW'(onehot2idx(16'(w_new_oh)));
    assign w_new_lock = |(w_new_oh & w_req_lock);
    assign w_own_idx  = MW'(onehot2idx(16'(r_hgrant)));
    assign w_own_lock = |(r_hgrant & w_req_lock);

    assign w_arb_pt = bus.hready &&
                      (bus.htrans == IDLE || bus.htrans == NONSEQ);
    assign w_rearb  = w_arb_pt && (r_state == GRANTED || !w_own_lock);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= GRANTED;
            r_hgrant    <= DEF_OH;
            r_rr_ptr    <= MW'(DEFAULT_MASTER);
            r_hmaster   <= MW'(DEFAULT_MASTER);
            r_hmastlock <= 1'b0;
        end else begin
            if (bus.hready) begin
                r_hmaster   <= w_own_idx;
                r_hmastlock <= w_own_lock;
            end
            if (w_rearb) begin
                r_hgrant <= w_new_oh;
                r_rr_ptr <= w_new_idx;
                r_state  <= w_new_lock ? LOCKED : GRANTED;
            end
        end
    end

    assign bus.hgrant    = r_hgrant;
    assign bus.hmaster   = r_hmaster;
    assign bus.hmastlock = r_hmastlock;

    a_onehot : assert property (
        @(posedge hclk) disable iff (!hresetn) $onehot(r_hgrant));
    a_range : assert property (
        @(posedge hclk) disable iff (!hresetn)
        int'(r_hmaster) < NUM_MASTERS);
endmodule

// File: tb/tb_minitb_ahb_arbiter.sv
// Directed bench for minitb_ahb_arbiter with a behavioural model
// of ownership, rotation and lock checked every cycle.
module tb_minitb_ahb_arbiter;
    localparam int N = 4;

    logic hclk;
    logic hresetn;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   go     = 0;

    minitb_ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

    minitb_ahb_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (0)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial begin
        hclk = 0;
        forever #5 hclk = ~hclk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: who owns the grant, whether it is held by a lock,
    // where rotation resumes, and the trailing data-phase owner.
    int m_owner, m_ptr, m_hm;
    bit m_locked, m_hml;

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            m_owner = 0; m_ptr = 0; m_hm = 0;
            m_locked = 0; m_hml = 0;
        end else begin
            int  old, nxt;
            bit  arb, hold, found;
            old  = m_owner;
            hold = bus.hlock[old] && bus.hbusreq[old];
            arb  = bus.hready &&
                   (bus.htrans == 2'b00 || bus.htrans == 2'b10);
            if (bus.hready) begin
                m_hm  = old;
                m_hml = hold;
            end
            if (arb && !(m_locked && hold)) begin
                nxt = 0; found = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && bus.hbusreq[(m_ptr + k) % N]) begin
                        nxt = (m_ptr + k) % N;
                        found = 1;
                    end
                end
                m_owner  = nxt;
                m_ptr    = nxt;
                m_locked = bus.hlock[nxt] && bus.hbusreq[nxt];
            end
        end
    end

    always @(negedge hclk) begin
        if (go && hresetn) begin
            check("mdl_hgrant", int'(bus.hgrant), 1 << m_owner);
            check("mdl_hmaster", int'(bus.hmaster), m_hm);
            check("mdl_hmastlock", int'(bus.hmastlock), int'(m_hml));
        end
    end

    task automatic step();
        @(negedge hclk);
        #2;
    endtask

    initial begin
        int order [5];
        int prev;
        order = '{1, 2, 3, 0, 1};
        hresetn     = 0;
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.htrans  = 2'b00;
        bus.hready  = 1;
        repeat (2) step();
        hresetn = 1;
        go = 1;

        for (int i = 0; i < 10; i++) begin
            step();
            check("t1_hgrant", int'(bus.hgrant), 1);
            check("t1_hmaster", int'(bus.hmaster), 0);
            check("t1_hmastlock", int'(bus.hmastlock), 0);
        end

        bus.hbusreq = 4'b0100;
        step();
        check("t2_hgrant", int'(bus.hgrant), 4);
        check("t2_hmaster_old", int'(bus.hmaster), 0);
        step();
        check("t2_hmaster", int'(bus.hmaster), 2);
        bus.hbusreq = '0;
        step();
        check("t2_default", int'(bus.hgrant), 1);
        step();

        bus.hbusreq = 4'b1111;
        bus.htrans  = 2'b10;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_rr_grant", int'(bus.hgrant), 1 << order[i]);
            check("t3_rr_hmaster", int'(bus.hmaster), prev);
            prev = order[i];
        end

        bus.hbusreq = '0;
        step();
        bus.hbusreq = 4'b1110;
        bus.hlock   = 4'b0010;
        step();
        check("t4_lock_grant", int'(bus.hgrant), 2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_grant", int'(bus.hgrant), 2);
            check("t4_hmastlock", int'(bus.hmastlock), 1);
            check("t4_hmaster", int'(bus.hmaster), 1);
        end
        bus.hlock = '0;
        step();
        check("t4_release", int'(bus.hgrant), 4);
        check("t4_unlock", int'(bus.hmastlock), 0);

        bus.htrans  = 2'b11;
        bus.hready  = 0;
        bus.hbusreq = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_wait_grant", int'(bus.hgrant), 4);
            check("t5_wait_hmaster", int'(bus.hmaster), 1);
        end
        bus.hready = 1;
        step();
        check("t5_seq_grant", int'(bus.hgrant), 4);
        check("t5_seq_hmaster", int'(bus.hmaster), 2);
        bus.htrans = 2'b00;
        step();
        check("t5_handover", int'(bus.hgrant), 8);

        bus.hbusreq = 4'b0100;
        bus.hlock   = 4'b0100;
        bus.htrans  = 2'b10;
        step();
        step();
        check("t6_pre_grant", int'(bus.hgrant), 4);
        check("t6_pre_lock", int'(bus.hmastlock), 1);
        check("t6_pre_hmaster", int'(bus.hmaster), 2);
        hresetn = 0;
        #1;
        check("t6_rst_grant", int'(bus.hgrant), 1);
        check("t6_rst_hmaster", int'(bus.hmaster), 0);
        check("t6_rst_lock", int'(bus.hmastlock), 0);
        #4;
        hresetn     = 1;
        bus.hbusreq = 4'b0110;
        bus.hlock   = '0;
        step();
        check("t6_post_grant0", int'(bus.hgrant), 1);
        step();
        check("t6_post_grant1", int'(bus.hgrant), 2);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
